mux4_scan_sequencer: RTL and testbench
======================================

# mux4_scan_sequencer

Sequential select-line driver placed directly upstream of the 4:1 multiplexer. It drives the mux select `S[1:0]`, steps through a masked subset of the four channels with a programmable dwell per channel, and samples the mux output `Y` back into a per-channel capture register. A `start`/`done` handshake runs one scan pass, so controller logic gets a 4-bit snapshot of `I[3:0]` taken through the mux.

## Interface
- `DWELL_W`, default 4: width of the dwell-count input.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level request for a scan pass; sampled only in IDLE.
- `ch_mask` input 4: channel enable mask; bit n=1 means channel n is scanned. Latched at start.
- `dwell` input DWELL_W: cycles each channel is held before sampling. 0 is treated as 1. Latched at start.
- `Y` input 1: output of the 4:1 mux.
- `S` output 2: mux select, registered.
- `captured` output 4: bit n holds the last sampled `Y` for channel n.
- `sample` output 1: one-cycle pulse after each capture.
- `sample_ch` output 2: channel index of the capture flagged by `sample`.
- `busy` output 1: high while in SCAN.
- `done` output 1: one-cycle pulse at the end of a pass.

## Operation
- **States:** IDLE and SCAN. A dwell counter and a latched mask/dwell register back the SCAN state.
- **Reset values:** state=IDLE, `S`=0, `captured`=0, `sample`=0, `sample_ch`=0, `busy`=0, `done`=0, counter=0.
- **IDLE, start=1 and ch_mask≠0:**
  - latch mask and effective dwell `D = (dwell==0) ? 1 : dwell`;
  - clear `captured` to 0;
  - set `S` to the lowest set mask bit and counter to 1;
  - go to SCAN.
- **IDLE, start=1 and ch_mask=0:** `done` pulses the next cycle, `captured` is cleared, and the state stays IDLE.
- **SCAN, counter<D:** increment the counter; `S` is held.
- **SCAN, counter==D:**
  - `captured[S] <= Y`, `sample <= 1`, `sample_ch <= S`;
  - if a higher masked channel exists, move `S` to the next higher set bit and set counter to 1;
  - otherwise `done <= 1` and go to IDLE, with `S` holding the last channel.
- `start` is ignored while in SCAN. Changes to `ch_mask` or `dwell` during SCAN have no effect.
- Channels whose mask bit is 0 are never selected and their `captured` bit stays 0.
- **Reset mid-scan:** on the next edge every output returns to its reset value, with no `done` and no `sample`.

## Timing
- Start is accepted on edge 0. SCAN runs cycles 1 through N·D, where N = popcount(mask).
- `Y` for the k-th enabled channel (k=1..N) is sampled on the edge ending cycle k·D.
- `sample` is high in cycle k·D+1.
- `S` changes on the same edge as each capture. The mux therefore always gets ≥D full cycles of settled select before its output is sampled.
- `done` and the final `sample` are both high in cycle N·D+1, and `busy` is 0 in that cycle.
- In that cycle the block is already in IDLE, so a held `start` is accepted back-to-back.
- Total latency from the start edge to `done`: N·D+1 cycles. Maximum with the default width: 4·15+1 = 61.

## Configuration
- `SCAN_CONTINUOUS_EN` defined:
  - at the end of a pass, if `start` is still 1, `done` still pulses;
  - SCAN restarts at the lowest latched channel with counter=1 and no idle cycle;
  - `captured` is not cleared between passes; each bit is overwritten in place;
  - if `start`=0 at the end of a pass, the block goes to IDLE.
- `SCAN_CONTINUOUS_EN` undefined: single-pass behaviour as described above; SCAN always exits to IDLE.

## Test plan
- **Reset:** assert `rst` mid-scan (mask=4'b1111, dwell=3, I=4'b1010) → next cycle all outputs are 0, the state is IDLE, and no `done` pulse appears.
- **Full pass:** mask=4'b1111, dwell=2, I=4'b1010 → `S` is 0,0,1,1,2,2,3,3 over cycles 1–8; `sample` pulses in cycles 3,5,7,9; `done` pulses in cycle 9; `captured`=4'b1010.
- **Sparse mask / dwell=0:** mask=4'b0101, dwell=0, I=4'b1111 → `S` is 0 then 2; `done` pulses in cycle 3; `captured`=4'b0101.
- **Empty mask:** mask=0 with `start` → `done` pulses one cycle later, `busy` never goes high, `captured`=0.
- **Start and input changes while busy:** pulse `start` again and change mask/dwell during SCAN → ignored; timing and `captured` match the first request.
- **Continuous mode (`SCAN_CONTINUOUS_EN`):** mask=4'b0011, dwell=1, `start` held high for 3 passes with I changing 2'b01→2'b10 after pass 1 → `done` pulses every 2 cycles (cycles 3, 5, 7); `captured[1:0]`=2'b10 after pass 2; IDLE after `start` drops.

Source files
------------

// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer: drives the select of a downstream 4:1 mux, walks the
// enabled channels with a programmable dwell, and captures the mux output per
// channel. One start/done handshake runs one scan pass.
// Optional feature macro: SCAN_CONTINUOUS_EN (rescan while start stays high).
module mux4_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               Y,
    output logic [1:0]         S,
    output logic [3:0]         captured,
    output logic               sample,
    output logic [1:0]         sample_ch,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         s_q, s_d;
    logic [3:0]         cap_q, cap_d;
    logic               sample_q, sample_d;
    logic [1:0]         sch_q, sch_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dw_q, dw_d;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Enabled channels strictly above the current one.
    function automatic logic [3:0] above_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [3:0] sh;
        sh = 4'b1110 << cur;
        return m & sh;
    endfunction

    // Next-state logic: channel stepping, dwell counting, capture and handshake.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cap_d    = cap_q;
        sample_d = 1'b0;
        sch_d    = sch_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        dw_d     = dw_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_d = 4'd0;
                    if (ch_mask != 4'd0) begin
                        mask_d  = ch_mask;
                        dw_d    = (dwell == '0) ? DWELL_W'(1) : dwell;
                        s_d     = lowest_ch(ch_mask);
                        cnt_d   = DWELL_W'(1);
                        state_d = SCAN;
                    end else begin
                        // Nothing to scan: acknowledge immediately.
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (cnt_q < dw_q) begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end else begin
                    cap_d[s_q] = Y;
                    sample_d   = 1'b1;
                    sch_d      = s_q;
                    if (above_ch(mask_q, s_q) != 4'd0) begin
                        s_d   = lowest_ch(above_ch(mask_q, s_q));
                        cnt_d = DWELL_W'(1);
                    end else begin
                        done_d = 1'b1;
`ifdef SCAN_CONTINUOUS_EN
                        // Held start rescans without an idle cycle; captures persist.
                        if (start) begin
                            s_d   = lowest_ch(mask_q);
                            cnt_d = DWELL_W'(1);
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= 2'd0;
            cap_q    <= 4'd0;
            sample_q <= 1'b0;
            sch_q    <= 2'd0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cap_q    <= cap_d;
            sample_q <= sample_d;
            sch_q    <= sch_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    // Latched request parameters; only meaningful while scanning.
    always_ff @(posedge clk) begin
        mask_q <= mask_d;
        dw_q   <= dw_d;
    end

    assign S         = s_q;
    assign captured  = cap_q;
    assign sample    = sample_q;
    assign sample_ch = sch_q;
    assign busy      = (state_q == SCAN);
    assign done      = done_q;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Testbench for mux4_scan_sequencer: randomized scan requests, expected events
// queued from a pass-level model, compared by an independent monitor.
module tb_mux4_scan_sequencer;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    ch_mask;
    logic [DW-1:0] dwell;
    logic          y;
    logic [1:0]    s;
    logic [3:0]    captured;
    logic          sample;
    logic [1:0]    sample_ch;
    logic          busy;
    logic          done;
    logic [3:0]    ivec;

    mux4_scan_sequencer #(.DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .dwell(dwell),
        .Y(y), .S(s), .captured(captured), .sample(sample),
        .sample_ch(sample_ch), .busy(busy), .done(done)
    );

    // The 4:1 mux the sequencer drives.
    assign y = ivec[s];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ecyc;
        logic       smp;
        logic       dn;
        logic [1:0] ch;
        logic [3:0] cap;
    } ev_t;

    ev_t        evq[$];
    int         exp_s[int];
    bit         exp_busy[int];
    logic [3:0] exp_cap;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic void chk(string nm, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, expv);
        end
    endfunction

    // Expected events of one pass whose accepting edge leaves cyc == p.
    task automatic push_pass(input int p, input logic [3:0] m, input int d_raw,
                             input logic [3:0] iv, input bit clr);
        int  dd;
        int  k;
        int  last;
        ev_t e;
        dd = (d_raw == 0) ? 1 : d_raw;
        k  = 0;
        last = 0;
        if (clr) exp_cap = 4'd0;
        for (int c = 0; c < 4; c++) if (m[c]) last = c;
        if (m == 4'd0) begin
            e.ecyc = p; e.smp = 1'b0; e.dn = 1'b1; e.ch = 2'd0; e.cap = exp_cap;
            evq.push_back(e);
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (m[c]) begin
                    k++;
                    for (int j = 0; j < dd; j++) begin
                        exp_s[p + (k - 1) * dd + j]    = c;
                        exp_busy[p + (k - 1) * dd + j] = 1'b1;
                    end
                    exp_cap[c] = iv[c];
                    e.ecyc = p + k * dd;
                    e.smp  = 1'b1;
                    e.dn   = (c == last);
                    e.ch   = 2'(c);
                    e.cap  = exp_cap;
                    evq.push_back(e);
                end
            end
        end
    endtask

    // Monitor: compares every presented sample/done against the queue.
    always @(negedge clk) begin
        ev_t e;
        while (evq.size() > 0 && evq[0].ecyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missed_event: expected at cyc %0d, still pending at cyc %0d", evq[0].ecyc, cyc);
            void'(evq.pop_front());
        end
        if (sample || done) begin
            if (evq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_event at cyc %0d: sample=%0b done=%0b, expected none", cyc, sample, done);
            end else begin
                e = evq.pop_front();
                chk("event_cycle", cyc, e.ecyc);
                chk("sample", sample, e.smp);
                chk("done", done, e.dn);
                if (e.smp) chk("sample_ch", sample_ch, e.ch);
                chk("captured", captured, e.cap);
            end
        end
        if (exp_s.exists(cyc)) chk("S", s, exp_s[cyc]);
        chk("busy", busy, exp_busy.exists(cyc));
    end

    // Issue one request at a negedge; start is held for exactly one edge.
    task automatic go(input logic [3:0] m, input logic [DW-1:0] d, input logic [3:0] iv,
                      output int p);
        ch_mask = m;
        dwell   = d;
        ivec    = iv;
        start   = 1'b1;
        p       = cyc + 1;
        push_pass(p, m, int'(d), iv, 1'b1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int p, input logic [3:0] m, input logic [DW-1:0] d);
        int dd;
        dd = (d == '0) ? 1 : int'(d);
        while (cyc < p + $countones(m) * dd) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p;
        int         r;
        logic [3:0] m;
        logic [3:0] iv;
        logic [DW-1:0] d;

        rst = 1'b1; start = 1'b0; ch_mask = 4'd0; dwell = '0; ivec = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_S", s, 0);
        chk("reset_captured", captured, 0);
        chk("reset_sample", sample, 0);
        chk("reset_sample_ch", sample_ch, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full pass.
        go(4'b1111, 4'd2, 4'b1010, p);
        wait_end(p, 4'b1111, 4'd2);
        chk("full_captured", captured, 4'b1010);

        // Sparse mask, dwell 0 behaves as 1.
        go(4'b0101, 4'd0, 4'b1111, p);
        wait_end(p, 4'b0101, 4'd0);
        chk("sparse_captured", captured, 4'b0101);

        // Empty mask.
        go(4'b0000, 4'd5, 4'b1111, p);
        wait_end(p, 4'b0000, 4'd5);
        chk("empty_captured", captured, 0);

        // Start and parameter changes while busy are ignored.
        go(4'b1111, 4'd2, 4'b1010, p);
        while (cyc < p + 2) @(negedge clk);
        start = 1'b1; ch_mask = 4'b0001; dwell = 4'd7;
        @(negedge clk);
        start = 1'b0;
        wait_end(p, 4'b1111, 4'd2);
        chk("busy_ignore_captured", captured, 4'b1010);

        // Reset in the middle of a pass.
        go(4'b1111, 4'd3, 4'b1010, p);
        while (cyc < p + 4) @(negedge clk);
        rst = 1'b1;
        r = cyc;
        while (evq.size() > 0 && evq[$].ecyc > r) void'(evq.pop_back());
        for (int c = r + 1; c <= r + 20; c++) begin
            if (exp_s.exists(c)) exp_s.delete(c);
            if (exp_busy.exists(c)) exp_busy.delete(c);
        end
        @(negedge clk);
        chk("midrst_S", s, 0);
        chk("midrst_captured", captured, 0);
        chk("midrst_sample", sample, 0);
        chk("midrst_sample_ch", sample_ch, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);

`ifdef SCAN_CONTINUOUS_EN
        // Held start: three back-to-back passes, input changes after pass 1.
        ch_mask = 4'b0011; dwell = 4'd1; ivec = 4'b0001; start = 1'b1;
        p = cyc + 1;
        push_pass(p,     4'b0011, 1, 4'b0001, 1'b1);
        push_pass(p + 2, 4'b0011, 1, 4'b0010, 1'b0);
        push_pass(p + 4, 4'b0011, 1, 4'b0010, 1'b0);
        while (cyc < p + 2) @(negedge clk);
        ivec = 4'b0010;
        while (cyc < p + 5) @(negedge clk);
        start = 1'b0;
        while (cyc < p + 8) @(negedge clk);
        chk("cont_captured", captured[1:0], 2'b10);
`else
        // Held start is accepted again in the done cycle.
        iv = 4'($urandom);
        ch_mask = 4'b0110; dwell = 4'd1; ivec = iv; start = 1'b1;
        p = cyc + 1;
        push_pass(p,     4'b0110, 1, iv, 1'b1);
        push_pass(p + 3, 4'b0110, 1, iv, 1'b1);
        while (cyc < p + 3) @(negedge clk);
        start = 1'b0;
        while (cyc < p + 7) @(negedge clk);
        chk("b2b_captured", captured, {1'b0, iv[2:1], 1'b0});
`endif

        // Randomized passes.
        repeat (25) begin
            m  = 4'($urandom_range(0, 15));
            d  = DW'($urandom_range(0, 15));
            iv = 4'($urandom);
            go(m, d, iv, p);
            wait_end(p, m, d);
            chk("rand_captured", captured, iv & m);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", evq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
